// File: rtl/adder_mux_display_pkg.sv
// Shared FSM type, 7-segment constants and sizing helpers for adder_mux_display.
package adder_mux_display_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_ZERO  = 7'h3F;

  // Segment order is {g,f,e,d,c,b,a}; non-decimal nibbles render blank.
  function automatic logic [6:0] seg_digit(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Bits needed for a counter spanning 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_mux_display_bin2bcd_seq.sv
// Sequential double-dabble converter: W binary bits into DIGITS BCD nibbles,
// one shift per cycle; the BCD output register holds until the next completion.
module bin2bcd_seq
  import adder_mux_display_pkg::*;
#(
  parameter int W      = 9,
  parameter int DIGITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [W-1:0]          i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int              CW   = cnt_width(W);
  localparam logic [CW-1:0]   LAST = CW'(W - 1);

  state_e                state_q, state_d;
  logic [W-1:0]          shift_q, shift_d;
  logic [4*DIGITS-1:0]   acc_q, acc_d, acc_adj;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  done_q, done_d;

  // Add-3 correction on every nibble that will overflow past 9 when doubled.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? (acc_q[4*i +: 4] + 4'd3)
                                                     : acc_q[4*i +: 4];
    end
  end

  // Next-state and datapath control for the IDLE/CONV sequencer.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          shift_d = i_bin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        shift_d = {shift_q[W-2:0], 1'b0};
        acc_d   = {acc_adj[4*DIGITS-2:0], shift_q[W-1]};
        if (cnt_q == LAST) begin
          // Final shift lands straight in the display register.
          disp_d  = {acc_adj[4*DIGITS-2:0], shift_q[W-1]};
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Converter state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
    end
  end

  assign o_busy = (state_q == CONV);
  assign o_done = done_q;
  assign o_bcd  = disp_q;

endmodule

// File: rtl/adder_mux_display.sv
// N-bit add/subtract with BCD conversion and a multiplexed 7-segment display.
// Define ADDER_MUX_DISPLAY_BLANK_EN to blank leading zeros and show a minus sign.
module adder_mux_display
  import adder_mux_display_pkg::*;
#(
  parameter int N                    = 8,
  parameter int DIGITS               = 3,
  parameter int REFRESH_DIV          = 50000,
  parameter int COMMON_ANODE_CATHODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N-1:0]      i_a,
  input  logic [N-1:0]      i_b,
  input  logic              i_sub,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [N:0]        o_sum,
  output logic              o_neg,
  output logic [6:0]        o_HEX,
  output logic [DIGITS-1:0] o_digit_en
);

  localparam int                W        = N + 1;
  localparam int                PW       = cnt_width(REFRESH_DIV);
  localparam int                IW       = cnt_width(DIGITS);
  localparam logic [PW-1:0]     PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic              INV      = (COMMON_ANODE_CATHODE != 0);
  localparam logic [6:0]        HEX_RST  = INV ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [DIGITS-1:0] EN_RST   = INV ? ~DIGITS'(1'b1) : DIGITS'(1'b1);

  logic                  eng_busy, eng_done, accept;
  logic [4*DIGITS-1:0]   disp_bcd;
  logic [W-1:0]          sum_raw, mag;
  logic                  neg_raw;
  logic [W-1:0]          sum_q, sum_d;
  logic                  neg_q, neg_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            hex_q, hex_d, seg;
  logic [DIGITS-1:0]     en_q, en_d, en_onehot;
  logic [3:0]            nib;
`ifdef ADDER_MUX_DISPLAY_BLANK_EN
  logic                  zero_run, blank_sel;
`endif

  // Arithmetic result, sign and magnitude; the result register loads only on an accepted start.
  always_comb begin
    if (i_sub) begin
      sum_raw = {1'b0, i_a} - {1'b0, i_b};
    end else begin
      sum_raw = {1'b0, i_a} + {1'b0, i_b};
    end
    neg_raw = i_sub & (i_a < i_b);
    if (neg_raw) begin
      mag = ~sum_raw + W'(1);
    end else begin
      mag = sum_raw;
    end
    accept = i_start & ~eng_busy;
    if (accept) begin
      sum_d = sum_raw;
      neg_d = neg_raw;
    end else begin
      sum_d = sum_q;
      neg_d = neg_q;
    end
  end

  bin2bcd_seq #(
    .W      (W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (accept),
    .i_bin   (mag),
    .o_busy  (eng_busy),
    .o_done  (eng_done),
    .o_bcd   (disp_bcd)
  );

  // Scan prescaler and digit index, free-running regardless of conversion state.
  always_comb begin
    pre_d = pre_q;
    idx_d = idx_q;
    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  // Decode from the next index so segments and enables switch on the same edge.
  always_comb begin
    nib = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      nib          = (idx_d == IW'(i)) ? disp_bcd[4*i +: 4] : nib;
      en_onehot[i] = (idx_d == IW'(i));
    end
`ifdef ADDER_MUX_DISPLAY_BLANK_EN
    zero_run  = 1'b1;
    blank_sel = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run  = zero_run & (disp_bcd[4*i +: 4] == 4'd0);
      blank_sel = ((idx_d == IW'(i)) && (i != 0)) ? zero_run : blank_sel;
    end
    // The sign can only occupy the leftmost digit, and only when it is blank.
    if (blank_sel) begin
      if (neg_q && (idx_d == IDX_LAST)) begin
        seg = SEG_MINUS;
      end else begin
        seg = SEG_BLANK;
      end
    end else begin
      seg = seg_digit(nib);
    end
`else
    seg = seg_digit(nib);
`endif
    hex_d = INV ? ~seg : seg;
    en_d  = INV ? ~en_onehot : en_onehot;
  end

  // Result, scan and display output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sum_q <= '0;
      neg_q <= 1'b0;
      pre_q <= '0;
      idx_q <= '0;
      hex_q <= HEX_RST;
      en_q  <= EN_RST;
    end else begin
      sum_q <= sum_d;
      neg_q <= neg_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      hex_q <= hex_d;
      en_q  <= en_d;
    end
  end

  assign o_busy     = eng_busy;
  assign o_done     = eng_done;
  assign o_sum      = sum_q;
  assign o_neg      = neg_q;
  assign o_HEX      = hex_q;
  assign o_digit_en = en_q;

endmodule

// File: tb/tb_adder_mux_display.sv
// Scoreboard bench for adder_mux_display: randomized and directed requests,
// expected results from decimal arithmetic, monitor checks at each o_done.
`timescale 1ns/1ps
module tb_adder_mux_display;

  localparam int N      = 8;
  localparam int DIGITS = 3;
  localparam int RD     = 4;
  localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      a = '0, b = '0;
  logic              sub = 1'b0, start = 1'b0;
  logic              busy, done, neg;
  logic [N:0]        sum;
  logic [6:0]        hex;
  logic [DIGITS-1:0] den;

  adder_mux_display #(
    .N(N), .DIGITS(DIGITS), .REFRESH_DIV(RD), .COMMON_ANODE_CATHODE(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_a(a), .i_b(b), .i_sub(sub), .i_start(start),
    .o_busy(busy), .o_done(done), .o_sum(sum), .o_neg(neg),
    .o_HEX(hex), .o_digit_en(den)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int sum;
    bit neg;
    int mag;
    int t0;
  } exp_t;

  exp_t exp_q[$];
  bit   mon_busy = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int digit_of(input int mag, input int d);
    int p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return (mag / p) % 10;
  endfunction

  function automatic int model_seg(input int mag, input bit sgn, input int d);
    int top = 0;
`ifdef ADDER_MUX_DISPLAY_BLANK_EN
    for (int k = 0; k < DIGITS; k++) if (digit_of(mag, k) != 0) top = k;
    if (d > top) return (sgn && d == DIGITS - 1) ? 32'h40 : 32'h00;
`endif
    return int'(PAT[digit_of(mag, d)]);
  endfunction

  function automatic int idx_of(input logic [DIGITS-1:0] en);
    int r = -1;
    for (int k = 0; k < DIGITS; k++) if (en[k]) r = k;
    return r;
  endfunction

  // Issue one request; when it should be accepted, push its expected result.
  task automatic do_start(input int ia, input int ib, input bit isub, input bit expect_acc);
    exp_t e;
    int   r;
    @(negedge clk);
    a = ia[N-1:0]; b = ib[N-1:0]; sub = isub; start = 1'b1;
    r     = isub ? (ia - ib) : (ia + ib);
    e.neg = (r < 0);
    e.mag = (r < 0) ? -r : r;
    e.sum = (r + 512) % 512;
    e.t0  = cyc + 1;
    if (expect_acc) exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    if (expect_acc) begin
      check("sum_after_edge0", int'(sum), e.sum);
      check("neg_after_edge0", int'(neg), int'(e.neg));
      check("busy_after_edge0", int'(busy), 1);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((exp_q.size() != 0 || mon_busy || busy) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", (k < 200) ? 1 : 0, 1);
  endtask

  // Monitor: pop on every o_done, check result, latency and a full display scan.
  initial begin : monitor
    exp_t e;
    bit [DIGITS-1:0] seen;
    int idx;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        mon_busy = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc - e.t0, N + 1);
          check("sum_at_done", int'(sum), e.sum);
          check("neg_at_done", int'(neg), int'(e.neg));
          check("busy_at_done", int'(busy), 0);
          seen = '0;
          for (int s = 0; s < 3 * RD + 2; s++) begin
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
            check("digit_en_onehot", $countones(den), 1);
            idx = idx_of(den);
            if (idx >= 0) begin
              seen[idx] = 1'b1;
              check("hex_digit", int'(hex), model_seg(e.mag, e.neg, idx));
            end
          end
          check("all_digits_scanned", int'(seen), (1 << DIGITS) - 1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    logic [DIGITS-1:0] prev;
    int run, changes;
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_neg", int'(neg), 0);
    check("rst_hex", int'(hex), 32'h3F);
    check("rst_digit_en", int'(den), 1);
    @(negedge clk);
    rst = 1'b0;

    do_start(200, 55, 1'b0, 1'b1);
    wait_idle();
    do_start(255, 255, 1'b0, 1'b1);
    wait_idle();
    do_start(10, 30, 1'b1, 1'b1);
    wait_idle();
    do_start(0, 0, 1'b1, 1'b1);
    wait_idle();
    do_start(0, 255, 1'b1, 1'b1);
    wait_idle();

    // Second request lands at edge 3 of a conversion and must be dropped.
    do_start(100, 23, 1'b1, 1'b1);
    @(negedge clk);
    do_start(7, 200, 1'b1, 1'b0);
    wait_idle();

    for (int t = 0; t < 12; t++) begin
      do_start(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'b1);
      wait_idle();
    end

    // Reset at edge 5 of a conversion aborts it.
    do_start(99, 1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_sum", int'(sum), 0);
    check("abort_hex", int'(hex), 32'h3F);
    check("abort_digit_en", int'(den), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3 * RD + 2; s++) begin
      @(negedge clk);
      check("abort_no_done", int'(done), 0);
      if (idx_of(den) >= 0)
        check("abort_hex_scan", int'(hex), model_seg(0, 1'b0, idx_of(den)));
    end

    // Idle scan: enables rotate 001->010->100->001, each held RD cycles.
    prev = den; run = 1; changes = 0;
    for (int s = 0; s < 8 * RD; s++) begin
      @(negedge clk);
      if (den != prev) begin
        check("scan_order", int'(den), int'({prev[DIGITS-2:0], prev[DIGITS-1]}));
        if (changes > 0) check("scan_slot_len", run, RD);
        changes++;
        prev = den;
        run  = 1;
      end else begin
        run++;
      end
    end
    check("scan_changes", (changes >= 6) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_mux_display.md
# adder_mux_display

Parametrised successor to the single-digit adder/display top. Registers an N-bit add or subtract on request and converts the magnitude to BCD with a sequential double-dabble engine. Drives a time-multiplexed DIGITS-wide 7-segment display through a shared segment bus and one-hot digit enables. Sits between board switches/buttons and the display pins.

## Interface
- N, 8, operand width in bits
- DIGITS, 3, display digits; must satisfy 10^DIGITS > 2^(N+1)-1
- REFRESH_DIV, 50000, clock cycles per digit scan slot; minimum 1
- COMMON_ANODE_CATHODE, 0, 0 = active-high segments and enables; 1 = all display outputs inverted
- i_clk  in  1  system clock
- i_rst  in  1  reset; asynchronous, active-high
- i_a  in  N  operand A
- i_b  in  N  operand B
- i_sub  in  1  0 = A+B, 1 = A−B
- i_start  in  1  one-cycle request; sampled only in IDLE
- o_busy  out  1  conversion in progress
- o_done  out  1  one-cycle pulse when the display value has been updated
- o_sum  out  N+1  registered raw result; two's complement when subtracting
- o_neg  out  1  result negative (subtract mode with A<B)
- o_HEX  out  7  segments {g,f,e,d,c,b,a}
- o_digit_en  out  DIGITS  one-hot digit select; bit 0 is the least significant digit

## Operation
- FSM states: IDLE and CONV.
- IDLE with i_start=1:
  - Register o_sum = A±B (N+1 bits, wrap modulo 2^(N+1)) and o_neg.
  - Load the shift register with magnitude |A±B| (N+1 bits), clear the BCD accumulator and the shift counter, then go to CONV.
- CONV: each cycle, add 3 to every BCD nibble ≥5, then shift left by one.
  - After N+1 shifts, copy the BCD accumulator to the display register, pulse o_done, and return to IDLE.
- i_start while in CONV is ignored; it is not queued.
- The display register holds its value until the next completed conversion.
- Scan logic runs independently of the FSM:
  - Prescaler counts 0..REFRESH_DIV−1.
  - On wrap, the digit index advances, DIGITS−1 wraps to 0.
  - o_HEX shows the decoded nibble of the selected digit.
  - Nibble values 10–15 decode to blank.
- Reset value of every output: o_busy=0, o_done=0, o_sum=0, o_neg=0, display register=0, digit index=0, o_digit_en=1 (one-hot digit 0), o_HEX=pattern '0' (0x3F).
  - With COMMON_ANODE_CATHODE=1, o_HEX and o_digit_en reset to the bitwise inverse.
- Reset mid-conversion aborts immediately: no o_done, and the display returns to 0.

## Timing
- i_start is sampled at edge 0.
- o_sum, o_neg, and o_busy=1 are valid after edge 0.
- Shifts occur at edges 1..N+1.
- After edge N+1: o_busy=0, o_done=1 for one cycle, and the new display value is visible.
- A new i_start is accepted at edge N+2 at the earliest.
- Latency from start to done is N+1 cycles; throughput is one result per N+2 cycles.
- Digit slot duration is exactly REFRESH_DIV cycles.
- o_digit_en and o_HEX change on the same edge; both are registered, with no glitch path.

## Configuration
- ADDER_MUX_DISPLAY_BLANK_EN defined:
  - Leading-zero digits are blanked; digit 0 is never blanked.
  - When o_neg=1, the most significant blank digit shows '−' (segment g only).
  - If no blank digit remains, no sign is shown.
- Undefined: all DIGITS shown with leading zeros, and no sign indication on the display.

## Structure
- Package adder_mux_display_pkg holds:
  - FSM state enum {IDLE, CONV}
  - 7-segment constants SEG_BLANK and SEG_MINUS
  - Digit pattern lookup function
  - Width helper for shift counter and prescaler (clog2)
- Natural sub-module: bin2bcd_seq, the double-dabble engine.
  - Ports: start, binary in, busy, done, BCD out; parametrised on N+1 and DIGITS.
- Top contains the result register, scan prescaler, digit mux, and output polarity.

## Test plan
Bench configuration: N=8, DIGITS=3, REFRESH_DIV=4, COMMON_ANODE_CATHODE=0.
- A=200, B=55, sub=0, start → o_sum=255 after edge 0, o_done at edge 9. Digits 2,5,5 → o_HEX 0x5B,0x6D,0x6D in slots 2,1,0.
- A=255, B=255, sub=0 → o_sum=510, digits 5,1,0, o_neg=0.
- A=10, B=30, sub=1 → o_sum=0x1EC, o_neg=1, digits 0,2,0. With BLANK_EN: slot 2 shows 0x40, slot 1 shows 0x5B.
- Start pulse at edge 3 of a conversion → ignored; exactly one o_done, and the value equals the first request.
- Assert i_rst at edge 5 of a conversion → o_busy=0, no o_done, all digits show 0x3F, o_digit_en=001.
- Idle scan → o_digit_en sequence 001,010,100,001, each held exactly 4 cycles.
